// File: rtl/spi_time_pkg.sv
// spi_time_pkg
//   Shared definitions for the SPI time-frame transmitter:
//   frame width, bit positions of each time/date field inside the
//   32-bit frame, the FSM state type and a helper that packs the fields.
package spi_time_pkg;

    localparam int FRAME_BITS = 32;

    localparam int HOUR_MSB = 31;
    localparam int HOUR_LSB = 27;
    localparam int MIN_MSB  = 26;
    localparam int MIN_LSB  = 21;
    localparam int SEC_MSB  = 20;
    localparam int SEC_LSB  = 15;
    localparam int MON_MSB  = 14;
    localparam int MON_LSB  = 11;
    localparam int DAY_MSB  = 10;
    localparam int DAY_LSB  = 6;
    localparam int YEAR_MSB = 5;
    localparam int YEAR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_HI = 2'd1,
        ST_SHIFT_LO = 2'd2
    } state_e;

    // Fields go in unchecked: out-of-range values are transmitted as given.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [4:0] hour,
        input logic [5:0] minute,
        input logic [5:0] second,
        input logic [3:0] month,
        input logic [4:0] day,
        input logic [5:0] year
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[HOUR_MSB:HOUR_LSB] = hour;
        f[MIN_MSB:MIN_LSB]   = minute;
        f[SEC_MSB:SEC_LSB]   = second;
        f[MON_MSB:MON_LSB]   = month;
        f[DAY_MSB:DAY_LSB]   = day;
        f[YEAR_MSB:YEAR_LSB] = year;
        return f;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer
//   Counts clk cycles while enabled and asserts tick in the last cycle of
//   each CLK_DIV-cycle sclk half-period. The counter is held at zero while
//   disabled so the first half-period after enabling is a full CLK_DIV long.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   enable - count while high
//   tick   - high in the final cycle of a half-period (combinational)
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_time_transmitter.sv
// spi_time_transmitter
//   Serialises one 32-bit time frame {hour, minute, second, month, day, year}
//   MSB first over a write-only SPI link. sdo changes only when sclk rises;
//   the receiver samples on the falling edge.
// Ports:
//   clk, reset                      - system clock, async active-high reset
//   start                           - one-cycle request, accepted only when idle
//   hour, minute, second,
//   month, day, year                - frame fields, latched at acceptance
//   sclk, sdo, cs_n, busy           - registered link/status outputs
//   done                            - one-cycle pulse in the last frame cycle
module spi_time_transmitter
    import spi_time_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [5:0] year,
    output logic       sclk,
    output logic       sdo,
    output logic       cs_n,
    output logic       busy,
    output logic       done
);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  tick;
    logic                  last_bit;

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    // bit_cnt_q is the index of the bit currently on the wire; when the low
    // phase of bit 31 ends, the 32nd falling edge has been delivered.
    assign last_bit = (bit_cnt_q == 5'd31);

    // done marks the cycle that ends the frame; the registered outputs
    // return to idle on the clock edge closing this cycle, so a start in
    // this cycle is still seen while busy and dropped.
    assign done = (state_q == ST_SHIFT_LO) && tick && last_bit;

    // sdo is the MSB of the shift register, so it only moves when the
    // register shifts (entering SHIFT_HI) and is cleared with the frame.
    assign sdo  = sh_q[FRAME_BITS-1];
    assign sclk = sclk_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT_HI;
                    sh_d      = pack_frame(hour, minute, second, month, day, year);
                    bit_cnt_d = '0;
                    sclk_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    state_d = ST_SHIFT_LO;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    if (last_bit) begin
                        state_d   = ST_IDLE;
                        sh_d      = '0;
                        bit_cnt_d = '0;
                        cs_n_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d   = ST_SHIFT_HI;
                        sh_d      = {sh_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        sclk_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_time_transmitter.sv
// tb_spi_time_transmitter
//   Self-checking bench: DUT A runs with CLK_DIV=4, DUT B with CLK_DIV=1.
//   Expected frames come from a weighted-sum model of the field layout;
//   received bits are collected from sdo at each sclk falling edge.
module tb_spi_time_transmitter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A (CLK_DIV = 4)
    logic       start_a = 1'b0;
    logic [4:0] hour_a = '0, day_a = '0;
    logic [5:0] minute_a = '0, second_a = '0, year_a = '0;
    logic [3:0] month_a = '0;
    logic       sclk_a, sdo_a, cs_n_a, busy_a, done_a;

    // DUT B (CLK_DIV = 1)
    logic       start_b = 1'b0;
    logic [4:0] hour_b = '0, day_b = '0;
    logic [5:0] minute_b = '0, second_b = '0, year_b = '0;
    logic [3:0] month_b = '0;
    logic       sclk_b, sdo_b, cs_n_b, busy_b, done_b;

    spi_time_transmitter #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .hour(hour_a), .minute(minute_a), .second(second_a),
        .month(month_a), .day(day_a), .year(year_a),
        .sclk(sclk_a), .sdo(sdo_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a)
    );

    spi_time_transmitter #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .hour(hour_b), .minute(minute_b), .second(second_b),
        .month(month_b), .day(day_b), .year(year_b),
        .sclk(sclk_b), .sdo(sdo_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b)
    );

    // Frame value as a weighted sum of the fields (hour weighted 2^27, etc).
    function automatic logic [31:0] model_frame(
        input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
        input logic [3:0] mo, input logic [4:0] d, input logic [5:0] y);
        longint v;
        v = longint'(h) * 134217728 + longint'(m) * 2097152 + longint'(s) * 32768
          + longint'(mo) * 2048 + longint'(d) * 64 + longint'(y);
        return v[31:0];
    endfunction

    // Sends one frame on DUT A and observes it cycle by cycle until done.
    // Cycle k=1 is the first cycle after the acceptance edge.
    task automatic run_a(
        input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
        input logic [3:0] mo, input logic [4:0] d, input logic [5:0] y,
        input bit scramble, input int inj_cycle, input bit inj_done,
        output logic [31:0] bits, output int nrise, output int nfall,
        output int done_k, output int csn_bad, output int busy_bad,
        output bit after_ok);
        int   k;
        logic prev;
        @(negedge clk);
        hour_a = h; minute_a = m; second_a = s; month_a = mo; day_a = d; year_a = y;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 1; prev = 1'b0; bits = '0; nrise = 0; nfall = 0;
        done_k = -1; csn_bad = 0; busy_bad = 0;
        while (done_k < 0 && k < 2000) begin
            if (sclk_a === 1'b1 && prev === 1'b0) nrise++;
            if (sclk_a === 1'b0 && prev === 1'b1) begin
                nfall++;
                bits = {bits[30:0], sdo_a};
            end
            prev = sclk_a;
            if (cs_n_a !== 1'b0) csn_bad++;
            if (busy_a !== 1'b1) busy_bad++;
            if (scramble && k == 5) begin
                hour_a = 5'($urandom); minute_a = 6'($urandom); second_a = 6'($urandom);
                month_a = 4'($urandom); day_a = 5'($urandom); year_a = 6'($urandom);
            end
            start_a = (k == inj_cycle);
            if (done_a === 1'b1) begin
                done_k = k;
                if (inj_done) start_a = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        start_a = 1'b0;
        after_ok = (busy_a === 1'b0) && (cs_n_a === 1'b1) && (sdo_a === 1'b0)
                && (sclk_a === 1'b0) && (done_a === 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
        checks++; if (sdo_a !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo_a); end
        checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (cs_n_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b: got cs_n=%b busy=%b expected 1/0", cs_n_b, busy_b); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        logic [31:0] bits; int nr, nf, dk, cb, bb; bit ok;
        run_a(5'd1, 6'd20, 6'd30, 4'd10, 5'd2, 6'd14, 1'b0, -1, 1'b0, bits, nr, nf, dk, cb, bb, ok);
        checks++; if (bits !== 32'h0A8F508E) begin errors++; $display("FAIL known_bits: got %h expected 0a8f508e", bits); end
        checks++; if (dk !== 256) begin errors++; $display("FAIL known_done_cycle: got %0d expected 256", dk); end
        checks++; if (!ok) begin errors++; $display("FAIL known_idle_after: got busy=%b cs_n=%b sdo=%b sclk=%b expected idle", busy_a, cs_n_a, sdo_a, sclk_a); end
    endtask

    task automatic test_max_fields();
        logic [31:0] bits; int nr, nf, dk, cb, bb; bit ok;
        run_a(5'd31, 6'd63, 6'd63, 4'd15, 5'd31, 6'd63, 1'b0, -1, 1'b0, bits, nr, nf, dk, cb, bb, ok);
        checks++; if (bits !== 32'hFFFFFFFF) begin errors++; $display("FAIL max_bits: got %h expected ffffffff", bits); end
        checks++; if (cb !== 0) begin errors++; $display("FAIL max_cs_n: got %0d cycles with cs_n high expected 0", cb); end
        checks++; if (nr !== 32) begin errors++; $display("FAIL max_rises: got %0d expected 32", nr); end
        checks++; if (nf !== 32) begin errors++; $display("FAIL max_falls: got %0d expected 32", nf); end
    endtask

    task automatic test_random_frames();
        logic [31:0] bits, exp; int nr, nf, dk, cb, bb; bit ok;
        logic [4:0] h, d; logic [5:0] m, s, y; logic [3:0] mo;
        for (int i = 0; i < 4; i++) begin
            h = 5'($urandom); m = 6'($urandom); s = 6'($urandom);
            mo = 4'($urandom); d = 5'($urandom); y = 6'($urandom);
            exp = model_frame(h, m, s, mo, d, y);
            // Fields are scrambled mid-frame; the frame must not change.
            run_a(h, m, s, mo, d, y, 1'b1, -1, 1'b0, bits, nr, nf, dk, cb, bb, ok);
            checks++; if (bits !== exp) begin errors++; $display("FAIL rand_bits[%0d]: got %h expected %h", i, bits, exp); end
            checks++; if (dk !== 256 || bb !== 0) begin errors++; $display("FAIL rand_timing[%0d]: got done@%0d busy_low=%0d expected 256/0", i, dk, bb); end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] bits, exp; int nr, nf, dk, cb, bb; bit ok; int extra;
        exp = model_frame(5'd7, 6'd45, 6'd3, 4'd12, 5'd25, 6'd33);
        run_a(5'd7, 6'd45, 6'd3, 4'd12, 5'd25, 6'd33, 1'b0, 10, 1'b1, bits, nr, nf, dk, cb, bb, ok);
        checks++; if (bits !== exp) begin errors++; $display("FAIL ignore_bits: got %h expected %h", bits, exp); end
        checks++; if (dk !== 256 || bb !== 0) begin errors++; $display("FAIL ignore_busy: got done@%0d busy_low=%0d expected 256/0", dk, bb); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy_a !== 1'b0 || cs_n_a !== 1'b1) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_frame: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] bits; int nr, nf, dk, cb, bb; bit ok;
        int falls, k, done_seen;
        logic prev;
        @(negedge clk);
        hour_a = 5'($urandom); minute_a = 6'($urandom); second_a = 6'($urandom);
        month_a = 4'($urandom); day_a = 5'($urandom); year_a = 6'($urandom);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        falls = 0; prev = 1'b0; k = 0;
        while (falls < 12 && k < 1000) begin
            if (sclk_a === 1'b0 && prev === 1'b1) falls++;
            prev = sclk_a;
            if (falls < 12) begin @(negedge clk); k++; end
        end
        checks++; if (falls !== 12) begin errors++; $display("FAIL midreset_reach: got %0d falls expected 12", falls); end
        #2 reset = 1'b1;
        #1;
        checks++; if (sclk_a !== 1'b0 || cs_n_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got sclk=%b cs_n=%b busy=%b done=%b expected 0/1/0/0", sclk_a, cs_n_a, busy_a, done_a);
        end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d done cycles expected 0", done_seen); end
        run_a('0, '0, '0, '0, '0, '0, 1'b0, -1, 1'b0, bits, nr, nf, dk, cb, bb, ok);
        checks++; if (bits !== 32'h0) begin errors++; $display("FAIL midreset_zero_bits: got %h expected 00000000", bits); end
        checks++; if (dk !== 256 || nf !== 32) begin errors++; $display("FAIL midreset_full_frame: got done@%0d falls=%0d expected 256/32", dk, nf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2, got1, got2;
        int done1, done2, ndone, low_cnt, gap_cnt;
        logic prev;
        @(negedge clk);
        hour_b = 5'($urandom); minute_b = 6'($urandom); second_b = 6'($urandom);
        month_b = 4'($urandom); day_b = 5'($urandom); year_b = 6'($urandom);
        exp1 = model_frame(hour_b, minute_b, second_b, month_b, day_b, year_b);
        exp2 = '0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        done1 = -1; done2 = -1; ndone = 0; low_cnt = 0; gap_cnt = 0;
        got1 = '0; got2 = '0; prev = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            start_b = 1'b0;
            if (sclk_b === 1'b0 && prev === 1'b1) begin
                if (ndone == 0) got1 = {got1[30:0], sdo_b};
                else            got2 = {got2[30:0], sdo_b};
            end
            prev = sclk_b;
            if (cs_n_b === 1'b0) low_cnt++;
            else if (ndone == 1) gap_cnt++;
            if (done1 > 0 && k == done1 + 1) begin
                hour_b = 5'($urandom); minute_b = 6'($urandom); second_b = 6'($urandom);
                month_b = 4'($urandom); day_b = 5'($urandom); year_b = 6'($urandom);
                exp2 = model_frame(hour_b, minute_b, second_b, month_b, day_b, year_b);
                start_b = 1'b1;
            end
            if (done_b === 1'b1) begin
                ndone++;
                if (ndone == 1) done1 = k;
                if (ndone == 2) done2 = k;
            end
            @(negedge clk);
        end
        start_b = 1'b0;
        checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
        checks++; if (done1 !== 64) begin errors++; $display("FAIL b2b_frame1_len: got done@%0d expected 64", done1); end
        checks++; if (done2 !== 129) begin errors++; $display("FAIL b2b_frame2_len: got done@%0d expected 129", done2); end
        checks++; if (gap_cnt !== 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 1", gap_cnt); end
        checks++; if (low_cnt !== 128) begin errors++; $display("FAIL b2b_cs_low: got %0d cycles expected 128", low_cnt); end
        checks++; if (got1 !== exp1) begin errors++; $display("FAIL b2b_bits1: got %h expected %h", got1, exp1); end
        checks++; if (got2 !== exp2) begin errors++; $display("FAIL b2b_bits2: got %h expected %h", got2, exp2); end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_max_fields();
        test_random_frames();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_time_transmitter.md
SPI_TIME_TRANSMITTER -- requirements
Module: spi_time_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per sclk half-period; legal values are 1 and above.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to send one time frame.
REQ-005 hour  input  5  hour field.
REQ-006 minute, second  input  6 each  minute and second fields, 0-59.
REQ-007 month  input  4, day  input  5, year  input  6  date fields, with year as an offset from 2000.
REQ-008 sclk  output  1  SPI clock to the downstream receiver, idle low.
REQ-009 sdo  output  1  serial data, MSB first.
REQ-010 cs_n  output  1  frame enable, low for the whole frame.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse at frame end.

Function
REQ-013 On start with busy low, the block SHALL latch frame = {hour, minute, second, month, day, year}; this places hour at [31:27], minute [26:21], second [20:15], month [14:11], day [10:6] and year [5:0].
REQ-014 Input fields SHALL be sent unchecked; no range clamping.
REQ-015 The FSM SHALL have states IDLE, SHIFT_HI and SHIFT_LO.
- IDLE -> SHIFT_HI on an accepted start.
- SHIFT_HI -> SHIFT_LO after CLK_DIV cycles.
- SHIFT_LO -> SHIFT_HI after CLK_DIV cycles if bits remain; otherwise SHIFT_LO -> IDLE.
REQ-016 In SHIFT_HI, sclk=1 and sdo = the current bit; in SHIFT_LO, sclk=0 and sdo is held.
REQ-017 The falling sclk edge (SHIFT_HI->SHIFT_LO) is the sampling edge; sdo SHALL change only on rising sclk edges.
REQ-018 sclk, sdo, cs_n and busy SHALL be registered outputs; the first SHIFT_HI values appear the cycle after start is sampled.
REQ-019 A 5-bit bit counter SHALL count 32 falling edges.
REQ-020 A frame SHALL last exactly 64*CLK_DIV cycles from the cycle after acceptance.
REQ-021 done SHALL pulse on the SHIFT_LO->IDLE transition; in that same cycle busy falls, cs_n rises and sdo returns to 0.
REQ-022 start while busy, including the done cycle, SHALL be ignored and not queued.
REQ-023 Input changes during a frame SHALL NOT affect the frame in flight.
REQ-024 Back-to-back frames: start asserted in the cycle after done SHALL be accepted.

Reset
REQ-025 While reset is high, the block SHALL be in IDLE with sclk=0, sdo=0, cs_n=1, busy=0, done=0, and the shift register and counters cleared.
REQ-026 Reset mid-frame SHALL abort immediately with no done pulse; the next start after reset releases sends a complete frame.

Structure
REQ-027 Package spi_time_pkg SHALL hold: FRAME_BITS=32; field MSB/LSB localparams for hour, minute, second, month, day and year; the FSM state enum type.
REQ-028 Sub-module spi_half_period_timer (parameter CLK_DIV; inputs clk, reset and enable; output tick) SHALL generate the phase ticks.

Verification
REQ-029 hour=1, minute=20, second=30, month=10, day=2, year=14, start, with CLK_DIV=4:
- The bench SHALL sample sdo on each sclk falling edge and collect 0x0A8F508E.
- done SHALL pulse exactly 256 cycles after the acceptance cycle.
REQ-030 All fields at maximum (31, 63, 63, 15, 31, 63) -> 0xFFFFFFFF; cs_n low throughout; exactly 32 sclk rising and 32 falling edges.
REQ-031 start pulsed at cycle 10 of a frame and again in the done cycle -> no extra frame; busy is continuous for one frame only.
REQ-032 reset asserted after 12 falling edges -> sclk=0, cs_n=1, busy=0 asynchronously with no done pulse; the next frame with all fields 0 -> 0x00000000.
REQ-033 CLK_DIV=1, two back-to-back starts (second start the cycle after done) -> two frames, each 64 cycles long, with a single idle cycle between them.
